// File: rtl/led_pkg.sv
// Shared constants for the LED pattern generator: pattern mode encodings,
// default board timing, and a width helper for the position register.
package led_pkg;

    localparam logic [1:0] MODE_LEFT     = 2'd0;
    localparam logic [1:0] MODE_RIGHT    = 2'd1;
    localparam logic [1:0] MODE_PINGPONG = 2'd2;
    localparam logic [1:0] MODE_BLINK    = 2'd3;

    // 100 ms and 25 ms at a 50 MHz board clock.
    localparam int unsigned T100MS = 5_000_000;
    localparam int unsigned T25MS  = 1_250_000;

    // A single-LED build still needs a 1-bit position register.
    function automatic int unsigned pos_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/led_step_timer.sv
// Step timer: counts 0..STEP_CYC-1 while enabled, holds while disabled,
// and flags the last cycle of each step both combinationally (for the
// position update in the parent) and as a registered Step_tick pulse.
module led_step_timer #(
    parameter int unsigned STEP_CYC = 10,
    parameter int unsigned CNT_W    = $clog2(STEP_CYC)
) (
    input  logic             CLK,
    input  logic             RSTn,
    input  logic             En,
    output logic [CNT_W-1:0] Count,
    output logic             boundary,
    output logic             Step_tick
);

    localparam logic [CNT_W-1:0] LAST = CNT_W'(STEP_CYC - 1);

    // A boundary only happens on an enabled cycle, so dropping En on the
    // last cycle suppresses both the wrap and the pattern advance.
    assign boundary = En && (Count == LAST);

    // Count advances and wraps only while enabled; the tick mirrors the boundary.
    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            Count     <= '0;
            Step_tick <= 1'b0;
        end else begin
            Step_tick <= boundary;
            if (En) begin
                Count <= boundary ? '0 : Count + CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/led_flow_gen.sv
// Multi-channel LED pattern generator: flow left, flow right, ping-pong
// and blink-all, each step lasting STEP_CYC cycles with the LEDs lit for
// the first ON_CYC cycles of the step.
module led_flow_gen
    import led_pkg::*;
#(
    parameter int unsigned N_LED    = 4,
    parameter int unsigned STEP_CYC = T100MS,
    parameter int unsigned ON_CYC   = T25MS,
    parameter int unsigned CNT_W    = $clog2(STEP_CYC)
) (
    input  logic             CLK,
    input  logic             RSTn,
    input  logic             En,
    input  logic [1:0]       Mode,
    output logic [N_LED-1:0] LED_out,
    output logic             Step_tick
);

    localparam int unsigned      POS_W   = pos_width(N_LED);
    localparam logic [POS_W-1:0] POS_MAX = POS_W'(N_LED - 1);

    logic [CNT_W-1:0] count;
    logic             boundary;
    logic [POS_W-1:0] pos;
    logic [POS_W-1:0] pos_nxt;
    logic             dir;
    logic             dir_nxt;
    logic [1:0]       cur_mode;
    logic [N_LED-1:0] pattern;
    logic             lit;

    led_step_timer #(
        .STEP_CYC (STEP_CYC),
        .CNT_W    (CNT_W)
    ) u_timer (
        .CLK       (CLK),
        .RSTn      (RSTn),
        .En        (En),
        .Count     (count),
        .boundary  (boundary),
        .Step_tick (Step_tick)
    );

    // Next position/direction, applied only at a step boundary. A new mode
    // restarts from its natural first position instead of advancing.
    always_comb begin
        pos_nxt = pos;
        dir_nxt = dir;
        if (Mode != cur_mode) begin
            dir_nxt = 1'b0;
            pos_nxt = (Mode == MODE_RIGHT) ? POS_MAX : '0;
        end else if (N_LED > 1) begin
            case (cur_mode)
                MODE_LEFT:  pos_nxt = (pos == POS_MAX) ? '0 : pos + POS_W'(1);
                MODE_RIGHT: pos_nxt = (pos == '0) ? POS_MAX : pos - POS_W'(1);
                MODE_PINGPONG: begin
                    if (!dir) begin
                        if (pos == POS_MAX) begin
                            pos_nxt = pos - POS_W'(1);
                            dir_nxt = 1'b1;
                        end else begin
                            pos_nxt = pos + POS_W'(1);
                        end
                    end else begin
                        if (pos == '0) begin
                            pos_nxt = pos + POS_W'(1);
                            dir_nxt = 1'b0;
                        end else begin
                            pos_nxt = pos - POS_W'(1);
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    // Pattern for the current step and whether we are inside the on-window.
    always_comb begin
        pattern = '0;
        for (int i = 0; i < int'(N_LED); i++) begin
            pattern[i] = (cur_mode == MODE_BLINK) || (int'(pos) == i);
        end
        lit = 32'(count) < ON_CYC;
    end

    // Pattern state updates at boundaries; LED drive is registered every cycle.
    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            pos      <= '0;
            dir      <= 1'b0;
            cur_mode <= MODE_LEFT;
            LED_out  <= '0;
        end else begin
            if (boundary) begin
                pos      <= pos_nxt;
                dir      <= dir_nxt;
                cur_mode <= Mode;
            end
            LED_out <= (En && lit) ? pattern : '0;
        end
    end

endmodule

// File: tb/tb_led_flow_gen.sv
// Bench for led_flow_gen with N_LED=4, STEP_CYC=10. Three instances share
// the stimulus: ON_CYC=4 (normal), ON_CYC=0 (always dark), ON_CYC=12
// (always lit). Each table row describes one step: the Mode applied while
// it runs and the one-hot/all-ones pattern it must show, plus optional
// En gaps, mid-step Mode glitches and an early stop for a mid-step reset.
module tb_led_flow_gen;

    logic       CLK;
    logic       RSTn;
    logic       En;
    logic [1:0] Mode;
    logic [3:0] led_n, led_d, led_l;
    logic       tick_n, tick_d, tick_l;

    int n_cmp  = 0;
    int n_fail = 0;

    led_flow_gen #(.N_LED(4), .STEP_CYC(10), .ON_CYC(4)) u_dut (
        .CLK(CLK), .RSTn(RSTn), .En(En), .Mode(Mode),
        .LED_out(led_n), .Step_tick(tick_n)
    );
    led_flow_gen #(.N_LED(4), .STEP_CYC(10), .ON_CYC(0)) u_dark (
        .CLK(CLK), .RSTn(RSTn), .En(En), .Mode(Mode),
        .LED_out(led_d), .Step_tick(tick_d)
    );
    led_flow_gen #(.N_LED(4), .STEP_CYC(10), .ON_CYC(12)) u_lit (
        .CLK(CLK), .RSTn(RSTn), .En(En), .Mode(Mode),
        .LED_out(led_l), .Step_tick(tick_l)
    );

    // Clock / reset block
    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    typedef struct {
        bit         rst;       // reset (mid-cycle) before this step
        logic [1:0] mode;      // Mode held during the step
        logic [3:0] pat;       // pattern expected during the step
        int         gap_at;    // cycle before which En drops for 5 cycles (-1 none)
        logic [1:0] gap_mode;  // Mode driven during a gap or glitch
        bit         glitch;    // Mode = gap_mode for cycles 4..7 of the step
        int         stop_at;   // number of step cycles to run (10 = full)
    } vec_t;

    vec_t vecs[$];

    task automatic add(input bit rst, input logic [1:0] mode, input logic [3:0] pat,
                       input int gap_at, input logic [1:0] gap_mode,
                       input bit glitch, input int stop_at);
        vec_t v;
        v.rst = rst; v.mode = mode; v.pat = pat; v.gap_at = gap_at;
        v.gap_mode = gap_mode; v.glitch = glitch; v.stop_at = stop_at;
        vecs.push_back(v);
    endtask

    task automatic chk(input string nm, input int row, input int cyc,
                       input logic [3:0] act, input logic [3:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s row=%0d cyc=%0d actual=%b required=%b", nm, row, cyc, act, exp);
        end
    endtask

    task automatic chk_all(input int row, input int cyc, input logic [3:0] e_n,
                           input logic [3:0] e_d, input logic [3:0] e_l, input logic e_t);
        chk("led_on4",   row, cyc, led_n, e_n);
        chk("led_on0",   row, cyc, led_d, e_d);
        chk("led_on12",  row, cyc, led_l, e_l);
        chk("tick_on4",  row, cyc, {3'b000, tick_n}, {3'b000, e_t});
        chk("tick_on12", row, cyc, {3'b000, tick_l}, {3'b000, e_t});
    endtask

    // Driver: asynchronous reset mid-cycle, then release at a falling edge.
    task automatic do_reset(input int row, input logic [1:0] mode);
        #2;
        RSTn = 1'b0;
        #1;
        chk_all(row, -1, 4'b0000, 4'b0000, 4'b0000, 1'b0);
        @(posedge CLK);
        @(negedge CLK);
        chk_all(row, -2, 4'b0000, 4'b0000, 4'b0000, 1'b0);
        Mode = mode;
        En   = 1'b1;
        RSTn = 1'b1;
    endtask

    // Driver + checker for one step.
    task automatic run_step(input int row, input vec_t r);
        Mode = r.mode;
        for (int c = 0; c < r.stop_at; c++) begin
            if (c == r.gap_at) begin
                Mode = r.gap_mode;
                En   = 1'b0;
                for (int g = 0; g < 5; g++) begin
                    @(posedge CLK);
                    @(negedge CLK);
                    chk_all(row, 100 + g, 4'b0000, 4'b0000, 4'b0000, 1'b0);
                end
                Mode = r.mode;
                En   = 1'b1;
            end
            if (r.glitch && c == 4) Mode = r.gap_mode;
            if (r.glitch && c == 8) Mode = r.mode;
            @(posedge CLK);
            @(negedge CLK);
            chk_all(row, c, (c < 4) ? r.pat : 4'b0000, 4'b0000, r.pat, (c == 9));
        end
    endtask

    initial begin
        RSTn = 1'b1;
        En   = 1'b0;
        Mode = 2'd0;

        // flow-left
        add(1, 2'd0, 4'b0001, -1, 2'd0, 0, 10);
        add(0, 2'd0, 4'b0010, -1, 2'd0, 0, 10);
        add(0, 2'd0, 4'b0100, -1, 2'd0, 0, 10);
        add(0, 2'd0, 4'b1000, -1, 2'd0, 0, 10);
        add(0, 2'd0, 4'b0001, -1, 2'd0, 0, 10);
        // flow-right: mode taken at the first boundary
        add(1, 2'd1, 4'b0001, -1, 2'd0, 0, 10);
        add(0, 2'd1, 4'b1000, -1, 2'd0, 0, 10);
        add(0, 2'd1, 4'b0100, -1, 2'd0, 0, 10);
        add(0, 2'd1, 4'b0010, -1, 2'd0, 0, 10);
        add(0, 2'd1, 4'b0001, -1, 2'd0, 0, 10);
        add(0, 2'd1, 4'b1000, -1, 2'd0, 0, 10);
        // ping-pong: entry restarts at 0, then 0,1,2,3,2,1,0,1
        add(1, 2'd2, 4'b0001, -1, 2'd0, 0, 10);
        add(0, 2'd2, 4'b0001, -1, 2'd0, 0, 10);
        add(0, 2'd2, 4'b0010, -1, 2'd0, 0, 10);
        add(0, 2'd2, 4'b0100, -1, 2'd0, 0, 10);
        add(0, 2'd2, 4'b1000, -1, 2'd0, 0, 10);
        add(0, 2'd2, 4'b0100, -1, 2'd0, 0, 10);
        add(0, 2'd2, 4'b0010, -1, 2'd0, 0, 10);
        add(0, 2'd2, 4'b0001, -1, 2'd0, 0, 10);
        add(0, 2'd2, 4'b0010, -1, 2'd0, 0, 10);
        // blink-all with mid-step Mode glitches that must be ignored
        add(1, 2'd3, 4'b0001, -1, 2'd0, 0, 10);
        add(0, 2'd3, 4'b1111, -1, 2'd0, 0, 10);
        add(0, 2'd3, 4'b1111, -1, 2'd0, 1, 10);
        add(0, 2'd3, 4'b1111, -1, 2'd1, 1, 10);
        add(0, 2'd3, 4'b1111, -1, 2'd0, 0, 10);
        // En gap mid-step, En drop with Mode change at the boundary,
        // then an asynchronous reset at Count=7, pos=2
        add(1, 2'd0, 4'b0001,  3, 2'd0, 0, 10);
        add(0, 2'd0, 4'b0010,  9, 2'd1, 0, 10);
        add(0, 2'd0, 4'b0100, -1, 2'd0, 0, 7);
        // restart after mid-step reset
        add(1, 2'd0, 4'b0001, -1, 2'd0, 0, 10);
        add(0, 2'd0, 4'b0010, -1, 2'd0, 0, 10);

        #1;
        foreach (vecs[i]) begin
            if (vecs[i].rst) do_reset(i, vecs[i].mode);
            run_step(i, vecs[i]);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
